// File: rtl/parity_checker.sv
// Receive-side parity checker: combinational error flag, a one-cycle
// registered error/valid pair, a sticky error flag and saturating
// word/error counters for link-quality monitoring.
module parity_checker #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] data_in,
  input  logic             parity_bit,
  input  logic             mode,
  input  logic             valid_in,
  input  logic             clr,
  output logic             error,
  output logic             err_q,
  output logic             valid_out,
  output logic             sticky_err,
  output logic [CNT_W-1:0] err_cnt,
  output logic [CNT_W-1:0] word_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  // Counter step that holds at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + 1'b1;
  endfunction

  logic             vld_q,    vld_d;
  logic             err_r_q,  err_r_d;
  logic             sticky_q, sticky_d;
  logic [CNT_W-1:0] ecnt_q,   ecnt_d;
  logic [CNT_W-1:0] wcnt_q,   wcnt_d;
  logic             hit;

  // Parity error of the live inputs; mode flips the expected parity.
  always_comb begin
    error = ^data_in ^ parity_bit ^ mode;
  end

  // Next-state for the pipeline register, sticky flag and counters.
  always_comb begin
    hit      = valid_in & error;
    vld_d    = valid_in;
    err_r_d  = hit;
    sticky_d = (sticky_q & ~clr) | hit;
    wcnt_d   = wcnt_q;
    ecnt_d   = ecnt_q;
    if (clr) begin
      wcnt_d = {{(CNT_W-1){1'b0}}, valid_in};
      ecnt_d = {{(CNT_W-1){1'b0}}, hit};
    end else begin
      if (valid_in) wcnt_d = sat_inc(wcnt_q);
      if (hit)      ecnt_d = sat_inc(ecnt_q);
    end
  end

  // State registers; reset clears everything so post-reset is a fresh start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q    <= 1'b0;
      err_r_q  <= 1'b0;
      sticky_q <= 1'b0;
      wcnt_q   <= '0;
      ecnt_q   <= '0;
    end else begin
      vld_q    <= vld_d;
      err_r_q  <= err_r_d;
      sticky_q <= sticky_d;
      wcnt_q   <= wcnt_d;
      ecnt_q   <= ecnt_d;
    end
  end

  assign err_q      = err_r_q;
  assign valid_out  = vld_q;
  assign sticky_err = sticky_q;
  assign err_cnt    = ecnt_q;
  assign word_cnt   = wcnt_q;

endmodule

// File: tb/tb_parity_checker.sv
// Bench for parity_checker: default instance plus a CNT_W=2 instance
// sharing the same stimulus, checked against a ones-counting model.
module tb_parity_checker;

  logic       clk, rst_n;
  logic [3:0] data_in;
  logic       parity_bit, mode, valid_in, clr;

  logic       error_a, err_q_a, valid_out_a, sticky_a;
  logic [7:0] err_cnt_a, word_cnt_a;
  logic       error_b, err_q_b, valid_out_b, sticky_b;
  logic [1:0] err_cnt_b, word_cnt_b;

  parity_checker #(.WIDTH(4), .CNT_W(8)) dut_a (
    .clk(clk), .rst_n(rst_n), .data_in(data_in), .parity_bit(parity_bit),
    .mode(mode), .valid_in(valid_in), .clr(clr), .error(error_a),
    .err_q(err_q_a), .valid_out(valid_out_a), .sticky_err(sticky_a),
    .err_cnt(err_cnt_a), .word_cnt(word_cnt_a));

  parity_checker #(.WIDTH(4), .CNT_W(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .data_in(data_in), .parity_bit(parity_bit),
    .mode(mode), .valid_in(valid_in), .clr(clr), .error(error_b),
    .err_q(err_q_b), .valid_out(valid_out_b), .sticky_err(sticky_b),
    .err_cnt(err_cnt_b), .word_cnt(word_cnt_b));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // reference state
  int m_word, m_errc;
  int m_word_b, m_errc_b;
  bit m_vout, m_errq, m_sticky;

  function automatic bit ref_err(input logic [3:0] d, input logic p, input logic m);
    int ones;
    ones = $countones({d, p});
    return m ? (ones % 2 == 0) : (ones % 2 == 1);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_word = 0; m_errc = 0; m_word_b = 0; m_errc_b = 0;
    m_vout = 0; m_errq = 0; m_sticky = 0;
  endtask

  task automatic chk_regs(input string tag);
    chk({tag, ".valid_out"}, {31'b0, valid_out_a}, {31'b0, m_vout});
    chk({tag, ".err_q"},     {31'b0, err_q_a},     {31'b0, m_errq});
    chk({tag, ".sticky"},    {31'b0, sticky_a},    {31'b0, m_sticky});
    chk({tag, ".word_cnt"},  {24'b0, word_cnt_a},  m_word);
    chk({tag, ".err_cnt"},   {24'b0, err_cnt_a},   m_errc);
    chk({tag, ".b.err_q"},   {31'b0, err_q_b},     {31'b0, m_errq});
    chk({tag, ".b.sticky"},  {31'b0, sticky_b},    {31'b0, m_sticky});
    chk({tag, ".b.word_cnt"},{30'b0, word_cnt_b},  m_word_b);
    chk({tag, ".b.err_cnt"}, {30'b0, err_cnt_b},   m_errc_b);
  endtask

  // One clocked word: check the combinational flag, clock, advance the model, check registers.
  task automatic step(input string tag, input logic [3:0] d, input logic p,
                      input logic m, input logic v, input logic c);
    bit e;
    data_in = d; parity_bit = p; mode = m; valid_in = v; clr = c;
    e = ref_err(d, p, m);
    #1;
    chk({tag, ".error"},   {31'b0, error_a}, {31'b0, e});
    chk({tag, ".b.error"}, {31'b0, error_b}, {31'b0, e});
    @(posedge clk);
    m_vout   = v;
    m_errq   = v & e;
    m_sticky = (m_sticky & ~c) | (v & e);
    if (c) begin
      m_word = v; m_errc = v & e; m_word_b = v; m_errc_b = v & e;
    end else begin
      if (v)     begin m_word = (m_word < 255) ? m_word + 1 : 255; m_word_b = (m_word_b < 3) ? m_word_b + 1 : 3; end
      if (v & e) begin m_errc = (m_errc < 255) ? m_errc + 1 : 255; m_errc_b = (m_errc_b < 3) ? m_errc_b + 1 : 3; end
    end
    #1;
    chk_regs(tag);
  endtask

  initial begin
    rst_n = 1'b0; data_in = 4'b0; parity_bit = 1'b0; mode = 1'b0;
    valid_in = 1'b0; clr = 1'b0;
    model_reset();
    #2;
    chk_regs("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // directed combinational truth points (valid low keeps counters idle)
    step("t_e0", 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
    step("t_e1", 4'b0001, 1'b1, 1'b0, 1'b0, 1'b0);
    step("t_e2", 4'b0001, 1'b0, 1'b0, 1'b0, 1'b0);
    step("t_o0", 4'b0000, 1'b1, 1'b1, 1'b0, 1'b0);
    step("t_o1", 4'b0001, 1'b0, 1'b1, 1'b0, 1'b0);
    step("t_o2", 4'b0001, 1'b1, 1'b1, 1'b0, 1'b0);

    // full sweep of data/parity per mode, combinational only
    for (int m = 0; m < 2; m++) begin
      for (int k = 0; k < 32; k++) begin
        logic [4:0] dp;
        dp = k[4:0];
        mode = m[0]; data_in = dp[4:1]; parity_bit = dp[0];
        #1;
        chk("sweep", {31'b0, error_a}, {31'b0, ref_err(dp[4:1], dp[0], m[0])});
      end
    end

    // pipeline, then sticky/clear sequence
    step("pipe_err",  4'b0001, 1'b0, 1'b0, 1'b1, 1'b0);
    step("pipe_idle", 4'b0001, 1'b0, 1'b0, 1'b0, 1'b0);
    step("clean1",    4'b0011, 1'b0, 1'b0, 1'b1, 1'b0);
    step("clean2",    4'b0111, 1'b0, 1'b1, 1'b1, 1'b0);
    step("clean3",    4'b1111, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("sticky_hold", {24'b0, word_cnt_a}, 32'd4);
    step("clr_err",   4'b0001, 1'b0, 1'b0, 1'b1, 1'b1);
    chk("clr_word",   {24'b0, word_cnt_a}, 32'd1);
    chk("clr_sticky", {31'b0, sticky_a},   32'd1);

    // saturation of the narrow counters
    step("sat_clr", 4'b0000, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) step("sat", 4'b1000, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("sat_errb",  {30'b0, err_cnt_b},  32'd3);
    chk("sat_wordb", {30'b0, word_cnt_b}, 32'd3);

    // async reset between edges with nonzero counters
    @(negedge clk);
    rst_n = 1'b0;
    model_reset();
    #1;
    chk_regs("async_rst");
    data_in = 4'b0110; parity_bit = 1'b1; mode = 1'b0;
    #1;
    chk("rst_error", {31'b0, error_a}, {31'b0, ref_err(4'b0110, 1'b1, 1'b0)});
    @(posedge clk); #1;
    chk_regs("rst_held");
    @(negedge clk);
    rst_n = 1'b1;
    step("post_rst", 4'b0010, 1'b1, 1'b1, 1'b1, 1'b0);

    // randomized traffic
    for (int i = 0; i < 300; i++) begin
      step("rand", 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0),
           1'($urandom_range(0, 31) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/parity_checker.md
Name: parity_checker

Overview:
- Parity checker for a WIDTH-bit data word plus one received parity bit.
- Supports even parity (mode=0) and odd parity (mode=1).
- Provides a combinational error flag for immediate use, a registered, valid-qualified error output, and a sticky error flag.
- Keeps saturating word and error counters for link-quality monitoring.
- Sits at the receive side of a parallel data path, after capture and before the consumer.

Parameters:
- WIDTH, 4, data word width in bits (≥1).
- CNT_W, 8, width of the word and error counters (≥2).

Ports:
- clk  input  1  system clock, rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- data_in  input  WIDTH  received data word.
- parity_bit  input  1  received parity bit.
- mode  input  1  0 = even parity, 1 = odd parity.
- valid_in  input  1  data_in/parity_bit/mode are valid this cycle.
- clr  input  1  synchronous clear of sticky flag and counters.
- error  output  1  combinational parity error of current inputs.
- err_q  output  1  registered error of the last valid word.
- valid_out  output  1  registered copy of valid_in.
- sticky_err  output  1  set on any valid erroneous word, held until clr.
- err_cnt  output  CNT_W  count of valid erroneous words, saturating.
- word_cnt  output  CNT_W  count of valid words checked, saturating.

Behaviour:
- error = XOR-reduce(data_in) ^ parity_bit ^ mode.
  - Purely combinational.
  - Independent of valid_in, clk and rst_n.
  - Even mode: error=1 when the total number of ones in {data_in, parity_bit} is odd.
  - Odd mode: error=1 when that total is even.
- Reset (rst_n=0, asynchronous, takes effect immediately): err_q, valid_out, sticky_err, err_cnt and word_cnt all go to 0. error still tracks its inputs during reset.
- Each rising clk with rst_n=1:
  - valid_out <= valid_in.
  - err_q <= valid_in ? error : 0. Latency is 1 cycle from input to err_q/valid_out.
  - sticky_err <= (sticky_err & ~clr) | (valid_in & error). A new error in the same cycle as clr leaves sticky_err=1.
  - word_cnt: if clr, <= valid_in ? 1 : 0. Otherwise, if valid_in and word_cnt != all-ones, increment. Otherwise hold.
  - err_cnt: if clr, <= (valid_in & error) ? 1 : 0. Otherwise, if valid_in & error and err_cnt != all-ones, increment. Otherwise hold.
- Saturation: the counters stick at 2^CNT_W−1 and never wrap.
- mode may change on any cycle. It is evaluated combinationally per word, with no pipeline interaction.
- No X-propagation requirements beyond standard synthesis. All outputs are defined after reset.
- Reset asserted mid-stream discards any in-flight err_q/valid_out. The first post-reset edge behaves as a fresh start.

Test Plan:
- Combinational truth, mode=0: (data_in=0000,p=0) -> error=0; (0001,1) -> 0; (0001,0) -> 1.
- Combinational truth, mode=1: (0000,1) -> error=0; (0001,0) -> 0; (0001,1) -> 1. Also sweep all 32 {data,p} combinations per mode against XOR-reduce ^ mode.
- Pipeline: valid_in=1 with (0001,0,mode 0) at edge N -> err_q=1, valid_out=1 after edge N. valid_in=0 next cycle -> err_q=0, valid_out=0, and counters unchanged.
- Sticky/clear: one erroneous valid word -> sticky_err=1, err_cnt=1, word_cnt=1. Then 3 clean words -> sticky_err=1, err_cnt=1, word_cnt=4. Then clr with an erroneous valid word the same cycle -> sticky_err=1, err_cnt=1, word_cnt=1.
- Saturation (CNT_W=2 override): 5 consecutive erroneous valid words -> err_cnt=3 and word_cnt=3, holding at 3.
- Async reset: assert rst_n=0 between edges with nonzero counters -> all registered outputs are 0 immediately. Release -> counting restarts from 0, while error keeps following its inputs throughout.
